// File: rtl/inbound_rx_decoder.sv
// Receive-side TLP decoder: single-DW BAR0 MRd32/MWr32 become register writes or
// completion requests for INBOUND_FSM; every other TLP is drained and counted.
module inbound_rx_decoder #(
  parameter int UNSUP_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            trn_rd,
  input  logic                   trn_rsof_n,
  input  logic                   trn_reof_n,
  input  logic                   trn_rsrc_rdy_n,
  input  logic                   trn_rsrc_dsc_n,
  input  logic [6:0]             trn_rbar_hit_n,
  output logic                   trn_rdst_rdy_n,
  output logic                   trn_rnp_ok_n,
  input  logic                   rx_np_ok_i,
  output logic [10:0]            wr_addr_o,
  output logic [7:0]             wr_be_o,
  output logic [31:0]            wr_data_o,
  output logic                   wr_en_o,
  input  logic                   wr_busy_i,
  output logic                   req_compl_o,
  output logic                   req_compl_with_data_o,
  input  logic                   compl_done_i,
  output logic [10:0]            rd_addr_o,
  output logic [3:0]             rd_be_o,
  output logic [2:0]             req_tc_o,
  output logic                   req_td_o,
  output logic                   req_ep_o,
  output logic [1:0]             req_attr_o,
  output logic [9:0]             req_len_o,
  output logic [15:0]            req_rid_o,
  output logic [7:0]             req_tag_o,
  output logic [7:0]             req_be_o,
  output logic [12:0]            req_addr_o,
  output logic [UNSUP_CNT_W-1:0] unsup_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_HDR2, S_WR_DATA, S_WR_STROBE, S_WR_WAIT, S_RD_WAIT, S_DISCARD
  } state_e;

  state_e                 state_q, state_d;
  logic                   rdst_rdy_n_q, rdst_rdy_n_d;
  logic [UNSUP_CNT_W-1:0] unsup_cnt_q, unsup_cnt_d;

  logic [6:0]  fmt_type_q;
  logic [2:0]  tc_q;
  logic        td_q, ep_q, bar0_q;
  logic [1:0]  attr_q;
  logic [9:0]  len_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [3:0]  last_be_q, first_be_q;
  logic [10:0] addr_q;
  logic [31:0] data_q;

  logic accept, sof, eof, dsc, mrd_ok, mwr_ok, unsup_inc;
  logic unused_bar_hits;

  assign accept = ~trn_rsrc_rdy_n & ~rdst_rdy_n_q;
  assign sof    = ~trn_rsof_n;
  assign eof    = ~trn_reof_n;
  assign dsc    = ~trn_rsrc_dsc_n;
  assign mrd_ok = (fmt_type_q == 7'h00) && (len_q == 10'd1) && bar0_q;
  assign mwr_ok = (fmt_type_q == 7'h40) && (len_q == 10'd1) && bar0_q;
  assign unused_bar_hits = &trn_rbar_hit_n[6:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rdst_rdy_n_q <= 1'b1;
      unsup_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rdst_rdy_n_q <= rdst_rdy_n_d;
      unsup_cnt_q  <= unsup_cnt_d;
    end
  end

  // Discontinue wins over every other decision on the beat that carries it.
  always_comb begin
    state_d   = state_q;
    unsup_inc = 1'b0;
    case (state_q)
      S_IDLE:    if (accept && sof) state_d = S_HDR1;
      S_HDR1:    if (accept) state_d = dsc ? S_IDLE : S_HDR2;
      S_HDR2: begin
        if (accept) begin
          if (dsc)                state_d = S_IDLE;
          else if (mrd_ok && eof) state_d = S_RD_WAIT;
          else if (mwr_ok)        state_d = S_WR_DATA;
          else begin
            unsup_inc = 1'b1;
            state_d   = eof ? S_IDLE : S_DISCARD;
          end
        end
      end
      S_WR_DATA: begin
        if (accept) begin
          if (dsc)      state_d = S_IDLE;
          else if (eof) state_d = S_WR_STROBE;
        end
      end
      S_WR_STROBE: state_d = S_WR_WAIT;
      S_WR_WAIT:   if (!wr_busy_i) state_d = S_IDLE;
      S_RD_WAIT:   if (compl_done_i) state_d = S_IDLE;
      S_DISCARD:   if (accept && (dsc || eof)) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdst_rdy_n_d = (state_d == S_WR_STROBE) || (state_d == S_WR_WAIT) ||
                   (state_d == S_RD_WAIT);
    unsup_cnt_d  = (unsup_inc && !(&unsup_cnt_q)) ? unsup_cnt_q + UNSUP_CNT_W'(1)
                                                  : unsup_cnt_q;
  end

  always_comb begin
    wr_en_o               = 1'b0;
    req_compl_o           = 1'b0;
    req_compl_with_data_o = 1'b0;
    case (state_q)
      S_WR_STROBE: wr_en_o = 1'b1;
      S_RD_WAIT: begin
        req_compl_o           = 1'b1;
        req_compl_with_data_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Header fields only load on accepted beats, so they hold through stalls and waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_type_q <= '0;
      tc_q       <= '0;
      td_q       <= 1'b0;
      ep_q       <= 1'b0;
      attr_q     <= '0;
      len_q      <= '0;
      bar0_q     <= 1'b0;
      rid_q      <= '0;
      tag_q      <= '0;
      last_be_q  <= '0;
      first_be_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (sof) begin
            fmt_type_q <= trn_rd[30:24];
            tc_q       <= trn_rd[22:20];
            td_q       <= trn_rd[15];
            ep_q       <= trn_rd[14];
            attr_q     <= trn_rd[13:12];
            len_q      <= trn_rd[9:0];
            bar0_q     <= ~trn_rbar_hit_n[0];
          end
        end
        S_HDR1: begin
          rid_q      <= trn_rd[31:16];
          tag_q      <= trn_rd[15:8];
          last_be_q  <= trn_rd[7:4];
          first_be_q <= trn_rd[3:0];
        end
        S_HDR2:    addr_q <= trn_rd[12:2];
        S_WR_DATA: if (eof) data_q <= trn_rd;
        default: ;
      endcase
    end
  end

  assign trn_rdst_rdy_n = rdst_rdy_n_q;
  assign trn_rnp_ok_n   = ~rx_np_ok_i;
  assign unsup_cnt_o    = unsup_cnt_q;
  assign wr_addr_o      = addr_q;
  assign wr_be_o        = {4'h0, first_be_q};
  assign wr_data_o      = data_q;
  assign rd_addr_o      = addr_q;
  assign rd_be_o        = first_be_q;
  assign req_tc_o       = tc_q;
  assign req_td_o       = td_q;
  assign req_ep_o       = ep_q;
  assign req_attr_o     = attr_q;
  assign req_len_o      = len_q;
  assign req_rid_o      = rid_q;
  assign req_tag_o      = tag_q;
  assign req_be_o       = {last_be_q, first_be_q};
  assign req_addr_o     = {addr_q, 2'b00};

endmodule

// File: doc/inbound_rx_decoder.md
# inbound_rx_decoder

Receive-side TLP decoder for the Spartan-6 PCIe endpoint: consumes 32-bit TRN receive beats from the hard block and drives the request/write interface of `INBOUND_FSM`. It decodes single-DW memory reads and writes to BAR0, drives either a register write (`wr_*`) or a completion request (`req_*`), and back-pressures the core until `INBOUND_FSM` has finished with the current TLP. All other TLPs are drained and counted.

## Interface
Parameters:
- `UNSUP_CNT_W`, default 8: width of the saturating unsupported-TLP counter.

Ports:
- `clk`  in  1  core clock (TRN user clock)
- `rst`  in  1  synchronous, active-high reset
- `trn_rd`  in  32  receive data beat
- `trn_rsof_n`  in  1  start of frame, active low
- `trn_reof_n`  in  1  end of frame, active low
- `trn_rsrc_rdy_n`  in  1  source ready, active low
- `trn_rsrc_dsc_n`  in  1  source discontinue, active low
- `trn_rbar_hit_n`  in  7  BAR hit, active low, valid on the SOF beat
- `trn_rdst_rdy_n`  out  1  destination ready, active low
- `trn_rnp_ok_n`  out  1  non-posted OK, active low; equals `~rx_np_ok_i`, combinational
- `rx_np_ok_i`  in  1  from `INBOUND_FSM`
- `wr_addr_o`  out  11  DW address for the write
- `wr_be_o`  out  8  write byte enables, `{4'h0, first_be}`
- `wr_data_o`  out  32  write data, taken from `trn_rd` unswapped
- `wr_en_o`  out  1  one-cycle write strobe
- `wr_busy_i`  in  1  write in progress
- `req_compl_o`  out  1  completion request, level
- `req_compl_with_data_o`  out  1  completion carries data
- `compl_done_i`  in  1  completion sent
- `rd_addr_o`  out  11  DW address for the read
- `rd_be_o`  out  4  first DW byte enables
- `req_tc_o` (3), `req_td_o` (1), `req_ep_o` (1), `req_attr_o` (2), `req_len_o` (10), `req_rid_o` (16), `req_tag_o` (8), `req_be_o` (8), `req_addr_o` (13): all outputs; header fields of the held request
- `unsup_cnt_o`  out  `UNSUP_CNT_W`  count of discarded TLPs, saturating

## Operation
- A beat is accepted when `trn_rsrc_rdy_n` and `trn_rdst_rdy_n` are both 0. Only accepted beats advance state.
- Header field positions:
  - DW0: `[30:24]` fmt/type, `[22:20]` TC, `[15]` TD, `[14]` EP, `[13:12]` attr, `[9:0]` length.
  - DW1: `[31:16]` RID, `[15:8]` tag, `[7:4]` last BE, `[3:0]` first BE.
  - DW2: `[31:2]` address.
- Supported TLPs:
  - MRd32: fmt/type 7'h00, length 1, BAR0 hit.
  - MWr32: fmt/type 7'h40, length 1, BAR0 hit.
  - Every other TLP goes to DISCARD.
- Address outputs:
  - `wr_addr_o` and `rd_addr_o` = `addr[12:2]`.
  - `req_addr_o` = `{addr[12:2], 2'b00}`.
  - `req_be_o` = `{last_be, first_be}`.
- States:
  - IDLE: `trn_rdst_rdy_n`=0. An accepted SOF beat latches DW0 and `bar_hit` → HDR1. A non-SOF beat is ignored.
  - HDR1: latch DW1 → HDR2.
  - HDR2: latch address.
    - MRd ok and EOF → RD_WAIT.
    - MWr ok → WR_DATA.
    - Else → DISCARD, or IDLE if this beat is EOF; the counter increments either way.
  - WR_DATA: accepted beat with EOF → WR_STROBE, latch data.
  - WR_STROBE: `wr_en_o`=1 for this single cycle; `trn_rdst_rdy_n`=1 → WR_WAIT.
  - WR_WAIT: `trn_rdst_rdy_n`=1; → IDLE on the first cycle `wr_busy_i`=0.
  - RD_WAIT: `req_compl_o`=`req_compl_with_data_o`=1, `trn_rdst_rdy_n`=1, all `req_*`/`rd_*` held stable; → IDLE on `compl_done_i`=1.
  - DISCARD: `trn_rdst_rdy_n`=0; → IDLE on an accepted EOF beat.
- Discontinue: an accepted beat with `trn_rsrc_dsc_n`=0 in HDR1, HDR2, WR_DATA or DISCARD → IDLE. No `wr_en_o`, no `req_compl_o`, counter unchanged.
- `unsup_cnt_o` saturates at all-ones and is incremented at most once per TLP.

## Timing
- Reset values:
  - `trn_rdst_rdy_n`=1 while `rst`=1, then 0 in IDLE.
  - All other registered outputs reset to 0; state resets to IDLE.
- Write path: the data beat is accepted in cycle N; `wr_en_o`=1 in N+1 only; `wr_busy_i` is sampled from N+2.
  - `trn_rdst_rdy_n` returns to 0 in the cycle after `wr_busy_i` is first seen 0.
  - Minimum: IDLE is re-entered at N+3.
- Read path: the EOF beat of DW2 is accepted in cycle N; `req_compl_o`=1 from N+1.
  - `req_compl_o` drops in the cycle after `compl_done_i`=1, when `trn_rdst_rdy_n` also returns to 0.
- `compl_done_i` asserted in the same cycle `req_compl_o` first rises is valid and honoured.
- Gaps in `trn_rsrc_rdy_n` at any beat stall in place with no output change.
- `rst` asserted in any state, including WR_WAIT and RD_WAIT, returns to reset values next cycle; the pending TLP is abandoned.

## Test plan
- MWr32 len 1, addr 0x40, BE 0xF, data 0xDEADBEEF, `wr_busy_i` held 3 cycles → one `wr_en_o` pulse with `wr_addr_o`=0x010, `wr_be_o`=0x0F, `wr_data_o`=0xDEADBEEF; `trn_rdst_rdy_n`=1 until busy clears.
- MRd32 len 1, addr 0x40, RID 0x0100, tag 0x05, BE 0xF; `compl_done_i` after 5 cycles → `req_compl_o`=1 for those cycles with `rd_addr_o`=0x010, `req_tag_o`=0x05, `req_rid_o`=0x0100, `req_len_o`=1, `req_compl_with_data_o`=1.
- Back-to-back MWr then MRd with a 2-cycle `trn_rsrc_rdy_n` gap inside HDR1 → both decoded correctly; the MRd SOF is accepted only after WR_WAIT exits.
- MWr len 2, then MRd64 (fmt/type 0x20), then MWr with `trn_rbar_hit_n`=7'h7D (BAR1) → all drained, no strobes, `unsup_cnt_o`=3; 256 such TLPs → `unsup_cnt_o` stays 0xFF.
- MWr discontinued on the HDR2 beat → no `wr_en_o`, counter unchanged, next MRd serviced normally.
- `rst` pulsed during RD_WAIT → `req_compl_o`=0 next cycle, `trn_rdst_rdy_n`=1 during reset, then 0; a new TLP is accepted.
